// File: rtl/match_record_writer.sv
// rtl/match_record_writer.sv - per-packet match capture, record queue and ring-buffer writer
module match_record_writer #(
    parameter logic [31:0] BASE_ADDR  = 32'h0000_0000,
    parameter int          RING_WORDS = 256,
    parameter int          QDEPTH     = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        valid,
    input  logic        sop,
    input  logic        eop,
    input  logic        error,
    input  logic        url_match,
    input  logic        mac_match,
    input  logic        ip_match,
    input  logic        port_match,
    input  logic        wait_request,
    output logic [31:0] addr_out,
    output logic [31:0] data_out,
    output logic        wr_en,
    output logic        clear,
    output logic [23:0] pkt_count,
    output logic [15:0] drop_count
);

    localparam int PW = $clog2(RING_WORDS);
    localparam int QW = $clog2(QDEPTH);

    typedef enum logic [1:0] {IDLE, IN_PKT, GRACE} cap_state_t;
    typedef enum logic [1:0] {W_IDLE, W_WORD0, W_WORD1} wr_state_t;

    cap_state_t cap_state;
    wr_state_t  w_state;

    logic [3:0]  flags;
    logic [15:0] len;
    logic        err;
    logic [3:0]  match_in;
    logic [3:0]  final_flags;
    logic        push;
    logic        pop;
    logic        push_ok;
    logic [43:0] rec_in;

    // Record queue: {seq[23:0], flags[3:0], len[15:0]}
    logic [43:0] mem [QDEPTH];
    logic [QW-1:0] q_wr_ptr;
    logic [QW-1:0] q_rd_ptr;
    logic [QW:0]   q_count;
    logic [43:0]   head;

    logic [PW-1:0] wptr;
    logic [PW-1:0] wptr_next;
    logic [31:0]   cur_addr;
    logic [31:0]   nxt_addr;
    logic [15:0]   hold_len;

    assign match_in    = {url_match, mac_match, ip_match, port_match};
    assign final_flags = flags | match_in;
    // The grace cycle still collects late comparator pulses for the finishing packet.
    assign push        = (cap_state == GRACE) && !err && (final_flags != 4'h0);
    assign rec_in      = {pkt_count, final_flags, len};
    assign pop         = (w_state == W_IDLE) && (q_count != '0);
    // A same-cycle pop frees a slot, so a push into a full queue can still land.
    assign push_ok     = push && ((q_count != QDEPTH[QW:0]) || pop);
    assign head        = mem[q_rd_ptr];

    assign wptr_next = wptr + 1'b1;
    assign cur_addr  = BASE_ADDR + {{(30-PW){1'b0}}, wptr, 2'b00};
    assign nxt_addr  = BASE_ADDR + {{(30-PW){1'b0}}, wptr_next, 2'b00};

    // Capture FSM: accumulate match flags, length and error over a packet
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cap_state <= IDLE;
            flags     <= 4'h0;
            len       <= 16'h0;
            err       <= 1'b0;
            pkt_count <= 24'h0;
            clear     <= 1'b0;
        end else begin
            clear <= (cap_state == GRACE);
            case (cap_state)
                IDLE: begin
                    if (valid && sop) begin
                        flags     <= match_in;
                        len       <= 16'h1;
                        err       <= error;
                        cap_state <= eop ? GRACE : IN_PKT;
                    end
                end
                IN_PKT: begin
                    if (valid && sop) begin
                        // Missing eop: discard the old packet and start over.
                        flags     <= match_in;
                        len       <= 16'h1;
                        err       <= error;
                        cap_state <= eop ? GRACE : IN_PKT;
                    end else begin
                        flags <= flags | match_in;
                        if (valid) begin
                            if (len != 16'hFFFF) begin
                                len <= len + 16'h1;
                            end
                            err <= err | error;
                            if (eop) begin
                                cap_state <= GRACE;
                            end
                        end
                    end
                end
                GRACE: begin
                    pkt_count <= pkt_count + 24'h1;
                    if (valid && sop) begin
                        // Match pulses this cycle belong to the previous packet.
                        flags     <= 4'h0;
                        len       <= 16'h1;
                        err       <= error;
                        cap_state <= eop ? GRACE : IN_PKT;
                    end else begin
                        cap_state <= IDLE;
                    end
                end
                default: cap_state <= IDLE;
            endcase
        end
    end

    // Queue storage write port
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[q_wr_ptr] <= rec_in;
        end
    end

    // Queue pointers, occupancy and saturating drop counter
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q_wr_ptr   <= '0;
            q_rd_ptr   <= '0;
            q_count    <= '0;
            drop_count <= 16'h0;
        end else begin
            if (push_ok) begin
                q_wr_ptr <= q_wr_ptr + 1'b1;
            end
            if (pop) begin
                q_rd_ptr <= q_rd_ptr + 1'b1;
            end
            case ({push_ok, pop})
                2'b10:   q_count <= q_count + 1'b1;
                2'b01:   q_count <= q_count - 1'b1;
                default: q_count <= q_count;
            endcase
            if (push && !push_ok && (drop_count != 16'hFFFF)) begin
                drop_count <= drop_count + 16'h1;
            end
        end
    end

    // Write FSM: two ring writes per record, outputs held while stalled
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            w_state  <= W_IDLE;
            wptr     <= '0;
            hold_len <= 16'h0;
            wr_en    <= 1'b0;
            addr_out <= 32'h0;
            data_out <= 32'h0;
        end else begin
            case (w_state)
                W_IDLE: begin
                    if (q_count != '0) begin
                        hold_len <= head[15:0];
                        wr_en    <= 1'b1;
                        addr_out <= cur_addr;
                        data_out <= {head[43:20], head[19:16], 4'h0};
                        w_state  <= W_WORD0;
                    end
                end
                W_WORD0: begin
                    if (!wait_request) begin
                        wptr     <= wptr_next;
                        addr_out <= nxt_addr;
                        data_out <= {16'h0, hold_len};
                        w_state  <= W_WORD1;
                    end
                end
                W_WORD1: begin
                    if (!wait_request) begin
                        wptr     <= wptr_next;
                        wr_en    <= 1'b0;
                        addr_out <= 32'h0;
                        data_out <= 32'h0;
                        w_state  <= W_IDLE;
                    end
                end
                default: w_state <= W_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_match_record_writer.sv
// tb/tb_match_record_writer.sv - scoreboard bench for match_record_writer
module tb_match_record_writer;

    logic        clk = 1'b0;
    logic        rst;
    logic        valid, sop, eop, error;
    logic        url_match, mac_match, ip_match, port_match;
    logic        wait_request;
    logic [31:0] addr_out, data_out;
    logic        wr_en, clear;
    logic [23:0] pkt_count;
    logic [15:0] drop_count;

    int tests_run    = 0;
    int tests_failed = 0;

    // Expected writes as {addr, data}
    logic [63:0] exp_q [$];

    match_record_writer #(
        .BASE_ADDR (32'h0000_0000),
        .RING_WORDS(4),
        .QDEPTH    (4)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .valid       (valid),
        .sop         (sop),
        .eop         (eop),
        .error       (error),
        .url_match   (url_match),
        .mac_match   (mac_match),
        .ip_match    (ip_match),
        .port_match  (port_match),
        .wait_request(wait_request),
        .addr_out    (addr_out),
        .data_out    (data_out),
        .wr_en       (wr_en),
        .clear       (clear),
        .pkt_count   (pkt_count),
        .drop_count  (drop_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%08h, required 0x%08h", name, act, exp);
        end
    endtask

    task automatic expect_write(input logic [31:0] a, input logic [31:0] d);
        exp_q.push_back({a, d});
    endtask

    // Present one cycle of stream inputs; m = {url, mac, ip, port}
    task automatic drive(input logic v, input logic s, input logic e, input logic er,
                         input logic [3:0] m);
        valid      = v;
        sop        = s;
        eop        = e;
        error      = er;
        url_match  = m[3];
        mac_match  = m[2];
        ip_match   = m[1];
        port_match = m[0];
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1'b0, 1'b0, 1'b0, 1'b0, 4'h0);
    endtask

    task automatic do_reset();
        rst          = 1'b1;
        wait_request = 1'b0;
        valid = 0; sop = 0; eop = 0; error = 0;
        url_match = 0; mac_match = 0; ip_match = 0; port_match = 0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic drain(input string name, input int n);
        idle(n);
        check(name, 32'(exp_q.size()), 32'd0);
    endtask

    // Monitor: every accepted write is compared against the scoreboard head
    always @(negedge clk) begin
        if (!rst && wr_en && !wait_request) begin
            if (exp_q.size() == 0) begin
                tests_run++;
                tests_failed++;
                $display("FAIL unexpected_write: addr 0x%08h data 0x%08h, none required",
                         addr_out, data_out);
            end else begin
                logic [63:0] e;
                e = exp_q.pop_front();
                check("write_addr", addr_out, e[63:32]);
                check("write_data", data_out, e[31:0]);
            end
        end
    end

    initial begin
        rst = 1'b1;
        do_reset();

        // Reset state
        check("rst_wr_en", {31'h0, wr_en}, 32'h0);
        check("rst_addr", addr_out, 32'h0);
        check("rst_data", data_out, 32'h0);
        check("rst_clear", {31'h0, clear}, 32'h0);
        check("rst_pkt_count", {8'h0, pkt_count}, 32'h0);
        check("rst_drop_count", {16'h0, drop_count}, 32'h0);

        // 5-beat packet, ip_match on beat 3
        expect_write(32'h0, 32'h0000_0020);
        expect_write(32'h4, 32'h0000_0005);
        drive(1, 1, 0, 0, 4'h0);
        drive(1, 0, 0, 0, 4'h0);
        drive(1, 0, 0, 0, 4'b0010);
        drive(1, 0, 0, 0, 4'h0);
        drive(1, 0, 1, 0, 4'h0);
        idle(1);
        check("t1_clear_high", {31'h0, clear}, 32'h1);
        check("t1_pkt_count", {8'h0, pkt_count}, 32'h1);
        check("t1_wr_en_not_yet", {31'h0, wr_en}, 32'h0);
        idle(1);
        check("t1_clear_low", {31'h0, clear}, 32'h0);
        check("t1_wr_en_latency", {31'h0, wr_en}, 32'h1);
        drain("t1_drain", 8);

        // Match pulse in the grace cycle counts; one cycle later it does not
        do_reset();
        expect_write(32'h0, 32'h0000_0010);
        expect_write(32'h4, 32'h0000_0002);
        drive(1, 1, 0, 0, 4'h0);
        drive(1, 0, 1, 0, 4'h0);
        drive(0, 0, 0, 0, 4'b0001);
        drain("t2a_drain", 8);
        drive(1, 1, 0, 0, 4'h0);
        drive(1, 0, 1, 0, 4'h0);
        idle(1);
        drive(0, 0, 0, 0, 4'b0001);
        drain("t2b_drain", 8);
        check("t2_pkt_count", {8'h0, pkt_count}, 32'h2);

        // Errored packet: no record, still counted and cleared
        do_reset();
        drive(1, 1, 0, 0, 4'b1000);
        drive(1, 0, 0, 1, 4'h0);
        drive(1, 0, 1, 0, 4'h0);
        idle(1);
        check("t3a_clear", {31'h0, clear}, 32'h1);
        check("t3a_pkt_count", {8'h0, pkt_count}, 32'h1);
        drain("t3a_drain", 6);

        // Abort by sop mid-packet: mac flag of the aborted packet must not leak
        expect_write(32'h0, 32'h0000_0120);
        expect_write(32'h4, 32'h0000_0002);
        drive(1, 1, 0, 0, 4'h0);
        drive(1, 0, 0, 0, 4'b0100);
        drive(1, 1, 0, 0, 4'h0);
        drive(1, 0, 1, 0, 4'b0010);
        idle(1);
        check("t3b_pkt_count", {8'h0, pkt_count}, 32'h2);
        drain("t3b_drain", 8);

        // Back-pressure: six back-to-back single-beat packets, one record dropped
        do_reset();
        wait_request = 1'b1;
        for (int k = 0; k < 5; k++) begin
            expect_write(32'((4 * ((2 * k) % 4))), 32'((k << 8) | 32'h10));
            expect_write(32'((4 * ((2 * k) % 4)) + 4), 32'h1);
        end
        for (int k = 0; k < 6; k++) drive(1, 1, 1, 0, 4'b0001);
        drive(0, 0, 0, 0, 4'b0001);
        idle(13);
        check("t4_drop_count", {16'h0, drop_count}, 32'h1);
        check("t4_pkt_count", {8'h0, pkt_count}, 32'h6);
        check("t4_held_wr_en", {31'h0, wr_en}, 32'h1);
        check("t4_held_addr", addr_out, 32'h0);
        check("t4_held_data", data_out, 32'h0000_0010);
        wait_request = 1'b0;
        drain("t4_drain", 25);

        // Ring wrap with three records
        do_reset();
        expect_write(32'h0, 32'h0000_0040);
        expect_write(32'h4, 32'h0000_0001);
        expect_write(32'h8, 32'h0000_0140);
        expect_write(32'hC, 32'h0000_0001);
        expect_write(32'h0, 32'h0000_0240);
        expect_write(32'h4, 32'h0000_0001);
        for (int k = 0; k < 3; k++) drive(1, 1, 1, 0, 4'b0100);
        drive(0, 0, 0, 0, 4'b0100);
        drain("t5_drain", 15);
        check("t5_drop_count", {16'h0, drop_count}, 32'h0);

        // Reset during a stalled second word
        do_reset();
        wait_request = 1'b1;
        expect_write(32'h0, 32'h0000_0080);
        drive(1, 1, 1, 0, 4'b1000);
        idle(2);
        check("t6_w0_wr_en", {31'h0, wr_en}, 32'h1);
        check("t6_w0_data", data_out, 32'h0000_0080);
        wait_request = 1'b0;
        idle(1);
        wait_request = 1'b1;
        check("t6_w1_wr_en", {31'h0, wr_en}, 32'h1);
        check("t6_w1_addr", addr_out, 32'h4);
        idle(1);
        rst = 1'b1;
        #1;
        check("t6_rst_wr_en", {31'h0, wr_en}, 32'h0);
        check("t6_rst_addr", addr_out, 32'h0);
        @(posedge clk);
        #1;
        rst          = 1'b0;
        wait_request = 1'b0;
        check("t6_scoreboard_after_rst", 32'(exp_q.size()), 32'd0);
        expect_write(32'h0, 32'h0000_0040);
        expect_write(32'h4, 32'h0000_0001);
        drive(1, 1, 1, 0, 4'b0100);
        drain("t6_drain", 8);
        check("t6_pkt_count", {8'h0, pkt_count}, 32'h1);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/match_record_writer.md
Name: match_record_writer

Overview:
- Downstream of the four field comparators (url/mac/ip/port) and the packet controller.
- Tracks each Avalon-ST packet, ORs the comparator match pulses over the packet, and on packet end queues a match record.
- Drains queued records to the result memory as two 32-bit writes into a circular buffer, honouring memory back-pressure.
- Pulses `clear` to re-arm the comparators between packets.

Parameters:
- BASE_ADDR, 32'h0000_0000, byte address of the result ring base.
- RING_WORDS, 256, ring size in 32-bit words; power of 2, >= 4.
- QDEPTH, 4, pending-record FIFO depth; power of 2, >= 2.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- valid  in  1  stream beat valid.
- sop  in  1  start of packet, qualified by valid.
- eop  in  1  end of packet, qualified by valid.
- error  in  1  beat error, qualified by valid.
- url_match  in  1  comparator match pulse.
- mac_match  in  1  comparator match pulse.
- ip_match  in  1  comparator match pulse.
- port_match  in  1  comparator match pulse.
- wait_request  in  1  memory stall; a write is accepted when wr_en=1 and wait_request=0.
- addr_out  out  32  write byte address.
- data_out  out  32  write data.
- wr_en  out  1  write strobe.
- clear  out  1  one-cycle comparator re-arm pulse.
- pkt_count  out  24  completed packets (sequence source).
- drop_count  out  16  records lost to a full queue, saturating.

Behaviour:
- Reset values: all outputs 0, ring pointer 0, queue empty, all state machines idle. Reset asserted mid-write abandons the write; wr_en drops immediately.
- flags[3:0] = {url, mac, ip, port}.
- Capture FSM states: IDLE, IN_PKT, GRACE.
  - IDLE: valid&sop loads flags from the current match inputs, sets len=1, err=error.
    - If eop is also set, go to GRACE; otherwise go to IN_PKT.
  - IDLE: eop or non-sop beats are ignored.
  - IN_PKT: every cycle, flags |= match inputs.
  - IN_PKT: each valid beat does len+1 (saturating at 16'hFFFF) and err |= error.
  - IN_PKT: valid&eop goes to GRACE.
  - IN_PKT: valid&sop without a prior eop aborts the packet: no record, no pkt_count change, restart as in IDLE.
  - GRACE (exactly one cycle): OR the match inputs one final time; they belong to the finishing packet.
    - If err==0 and final flags!=0, push record {seq=pkt_count, flags, len}.
    - pkt_count increments (wraps at 2^24), including errored packets.
    - Return to IDLE. A valid&sop in this cycle is handled as from IDLE, with new flags starting at 0.
- clear is registered: high for exactly the cycle after GRACE.
- Queue:
  - A push while full drops the record and increments drop_count (saturating at 16'hFFFF).
  - A pop in the same cycle frees a slot first, so a push while full succeeds if a pop occurs that cycle.
- Write FSM states: W_IDLE, W_WORD0, W_WORD1.
  - W_IDLE: if the queue is non-empty, pop into the holding register and go to W_WORD0.
  - W_WORD0: wr_en=1, addr_out=BASE_ADDR+4*wptr, data_out={seq[23:0], flags, 4'h0}.
  - W_WORD1: wr_en=1, addr_out=BASE_ADDR+4*wptr, data_out={16'h0, len}.
  - In each word state, on acceptance do wptr+1 mod RING_WORDS and advance to the next state.
  - Minimum 3 cycles per record.
  - addr_out and data_out are held stable while wr_en&wait_request.
  - addr_out and data_out are 0 in W_IDLE.
- The ring wraps silently; no read-pointer or overrun detection.
- Latency: with wait_request=0, the first write asserts 2 cycles after the GRACE cycle (push, then pop).

Test Plan:
- 5-beat packet, ip_match pulse on beat 3, wait_request=0 -> two writes:
  - addr 0x0 data 0x0000_0020.
  - addr 0x4 data 0x0000_0005.
  - clear high 1 cycle; pkt_count=1.
- Match timing:
  - port_match in the cycle after eop -> word0 = 0x0000_0010.
  - port_match 2 cycles after eop -> no write.
- Errors and aborts:
  - error on beat 2, url_match set -> no writes, pkt_count increments, clear still pulses.
  - sop mid-packet -> first packet discarded, pkt_count unchanged.
- Back-pressure: wait_request held high 20 cycles while six matching single-beat packets arrive back-to-back ->
  - 1 record held, 4 queued, drop_count=1.
  - After release, 5 records written with seq 0..4 in order.
- Wrap: RING_WORDS=4, three matching packets -> write addresses 0x0, 0x4, 0x8, 0xC, 0x0, 0x4.
- Reset:
  - rst asserted during W_WORD1 with wait_request=1 -> wr_en=0 immediately.
  - After release, the next record writes to BASE_ADDR with seq 0.
